// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU with start/busy/done handshake, iterative multiply and optional divide (ALU_MC_DIV_EN)
module alu_multicycle #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int IMM_W   = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [3:0]         ctrl_i,
   input  logic [WIDTH-1:0]   src1_i,
   input  logic [WIDTH-1:0]   src2_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   input  logic [IMM_W-1:0]   imm_i,
   output logic [WIDTH-1:0]   result_o,
   output logic [WIDTH-1:0]   hi_o,
   output logic               zero_o,
   output logic               busy_o,
   output logic               done_o
);
   typedef enum logic {IDLE, RUN} state_t;
   localparam logic [SHAMT_W-1:0] LAST = SHAMT_W'(WIDTH - 1);
   state_t               state_q;
   logic [SHAMT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]     result_q, hi_q, b_q, alu_d;
   logic                 zero_q, done_q, is_multi;
   logic [2*WIDTH-1:0]   p_q, p_d, mul_d;
   logic [WIDTH:0]       msum;
   assign result_o = result_q;
   assign hi_o     = hi_q;
   assign zero_o   = zero_q;
   assign busy_o   = state_q == RUN;
   assign done_o   = done_q;
   // p_q holds {accumulator, multiplier}; add the multiplicand when the lsb is set, then shift right
   assign msum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : '0);
   assign mul_d = {msum, p_q[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
   logic           div_q;
   logic [WIDTH:0] dsh, ddiff;
   logic [2*WIDTH-1:0] div_d;
   // restoring divide: p_q holds {remainder, dividend/quotient}; a zero divisor naturally yields all-ones and the dividend
   assign dsh      = p_q[2*WIDTH-1:WIDTH-1];
   assign ddiff    = dsh - {1'b0, b_q};
   assign div_d    = ddiff[WIDTH] ? {dsh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                                  : {ddiff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
   assign p_d      = div_q ? div_d : mul_d;
   assign is_multi = ctrl_i == 4'b1000 || ctrl_i == 4'b1011;
`else
   assign p_d      = mul_d;
   assign is_multi = ctrl_i == 4'b1000;
`endif
   // single-cycle operation decode; unlisted codes give zero
   always_comb begin
      alu_d = '0;
      case (ctrl_i)
         4'b0000: alu_d = src1_i & src2_i;
         4'b0001: alu_d = src1_i | src2_i;
         4'b0010: alu_d = src1_i + src2_i;
         4'b0110: alu_d = src1_i - src2_i;
         4'b1100: alu_d = ~(src1_i | src2_i);
         4'b1101: alu_d = ~(src1_i & src2_i);
         4'b0111: alu_d = WIDTH'($signed(src1_i) < $signed(src2_i));
         4'b0101: alu_d = WIDTH'(src1_i < src2_i);
         4'b0011: alu_d = src2_i << shamt_i;
         4'b0100: alu_d = src2_i >> src1_i[SHAMT_W-1:0];
         4'b1110: alu_d = $unsigned($signed(src2_i) >>> shamt_i);
         4'b1001: alu_d = WIDTH'(imm_i) << (WIDTH - IMM_W);
         4'b1010: alu_d = src1_i | WIDTH'(imm_i);
         4'b1111: alu_d = src1_i;
         default: alu_d = '0;
      endcase
   end
   // handshake FSM: single-cycle ops complete on the accepting edge, mul/div iterate WIDTH times in RUN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         result_q <= '0;
         hi_q     <= '0;
         zero_q   <= 1'b1;
         done_q   <= 1'b0;
         p_q      <= '0;
         b_q      <= '0;
`ifdef ALU_MC_DIV_EN
         div_q    <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         if (state_q == IDLE) begin
            if (start_i) begin
               cnt_q <= '0;
               p_q   <= {{WIDTH{1'b0}}, src1_i};
               b_q   <= src2_i;
`ifdef ALU_MC_DIV_EN
               div_q <= ctrl_i == 4'b1011;
`endif
               if (is_multi) state_q <= RUN;
               else begin
                  result_q <= alu_d;
                  hi_q     <= '0;
                  zero_q   <= alu_d == '0;
                  done_q   <= 1'b1;
               end
            end
         end else begin
            p_q   <= p_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_q  <= IDLE;
               result_q <= p_d[WIDTH-1:0];
               hi_q     <= p_d[2*WIDTH-1:WIDTH];
               zero_q   <= p_d[WIDTH-1:0] == '0;
               done_q   <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed vectors checked against a cycle-level behavioural model plus literal expectations
module tb_alu_multicycle;
   localparam int W = 32;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [3:0]  ctrl = '0;
   logic [31:0] a = '0, b = '0;
   logic [4:0]  sh = '0;
   logic [15:0] imm = '0;
   logic [31:0] res, hi;
   logic        zero, busy, done;
   int          n_chk = 0, n_fail = 0;
   int          cyc, bc;
   always #5 clk = ~clk;
   alu_multicycle #(.WIDTH(32), .SHAMT_W(5), .IMM_W(16)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .ctrl_i(ctrl), .src1_i(a), .src2_i(b),
      .shamt_i(sh), .imm_i(imm), .result_o(res), .hi_o(hi), .zero_o(zero), .busy_o(busy), .done_o(done)
   );
   function automatic logic [63:0] model(input logic [3:0] c, input logic [31:0] x, y, input logic [4:0] s, input logic [15:0] i);
      logic [63:0] r;
      r = '0;
      case (c)
         4'h0: r[31:0] = x & y;
         4'h1: r[31:0] = x | y;
         4'h2: r[31:0] = x + y;
         4'h6: r[31:0] = x - y;
         4'hC: r[31:0] = ~(x | y);
         4'hD: r[31:0] = ~(x & y);
         4'h7: r[31:0] = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'h5: r[31:0] = (x < y) ? 32'd1 : 32'd0;
         4'h3: r[31:0] = y << s;
         4'h4: r[31:0] = y >> x[4:0];
         4'hE: r[31:0] = $signed(y) >>> s;
         4'h9: r[31:0] = {i, 16'h0};
         4'hA: r[31:0] = x | {16'h0, i};
         4'hF: r[31:0] = x;
         4'h8: r = {32'h0, x} * {32'h0, y};
`ifdef ALU_MC_DIV_EN
         4'hB: r = (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
`endif
         default: r = '0;
      endcase
      return r;
   endfunction
   function automatic bit multi(input logic [3:0] c);
`ifdef ALU_MC_DIV_EN
      return c == 4'h8 || c == 4'hB;
`else
      return c == 4'h8;
`endif
   endfunction
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   int          m_rem = 0;
   logic        m_done;
   logic [31:0] m_res, m_hi;
   logic [63:0] m_pend;
   bit          chk_en = 0;
   always @(posedge clk) begin
      chk_en <= 1;
      if (rst) begin
         m_rem <= 0; m_done <= 0; m_res <= '0; m_hi <= '0;
      end else if (m_rem != 0) begin
         m_rem  <= m_rem - 1;
         m_done <= m_rem == 1;
         if (m_rem == 1) begin
            m_res <= m_pend[31:0];
            m_hi  <= m_pend[63:32];
         end
      end else if (start) begin
         if (multi(ctrl)) begin
            m_rem  <= W;
            m_pend <= model(ctrl, a, b, sh, imm);
            m_done <= 0;
         end else begin
            {m_hi, m_res} <= model(ctrl, a, b, sh, imm);
            m_done <= 1;
         end
      end else m_done <= 0;
   end
   always @(negedge clk) begin
      if (chk_en) begin
         chk("model busy", busy, m_rem != 0);
         chk("model done", done, m_done);
         chk("model result", res, m_res);
         chk("model hi", hi, m_hi);
         chk("model zero", zero, m_res == 0);
      end
   end
   task automatic drive(input logic [3:0] c, input logic [31:0] x, y, input logic [4:0] s, input logic [15:0] i);
      ctrl = c; a = x; b = y; sh = s; imm = i; start = 1'b1;
   endtask
   task automatic issue(input logic [3:0] c, input logic [31:0] x, y, input logic [4:0] s, input logic [15:0] i);
      @(negedge clk);
      drive(c, x, y, s, i);
      @(negedge clk);
      start = 1'b0;
   endtask
   task automatic wait_done(input int from, output int c, output int bcnt);
      c = from;
      bcnt = 0;
      while (!done && c < 100) begin
         if (busy) bcnt++;
         @(negedge clk);
         c++;
      end
      if (!done) begin
         n_chk++;
         n_fail++;
         $display("FAIL timeout: done_o not seen within %0d cycles", c);
      end
   endtask
   logic [3:0]  t_c[13] = '{4'h1, 4'h2, 4'h6, 4'hC, 4'hD, 4'h3, 4'h4, 4'h9, 4'hA, 4'hF, 4'h7, 4'h5, 4'hE};
   logic [31:0] t_a[13] = '{32'hF0F00000, 32'hFFFFFFFF, 32'h0, 32'hFFFF0000, 32'hFFFFFFFF, 32'h0, 32'h24,
                            32'h0, 32'h12340000, 32'hDEADBEEF, 32'h1, 32'h1, 32'h0};
   logic [31:0] t_b[13] = '{32'h0000F0F0, 32'h2, 32'h1, 32'h00FF0000, 32'hFFFFFFFF, 32'h1, 32'h80000000,
                            32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h40000000};
   logic [4:0]  t_s[13] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4};
   logic [15:0] t_i[13] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1234, 16'hABCD, 16'h0, 16'h0, 16'h0, 16'h0};
   logic [31:0] t_e[13] = '{32'hF0F0F0F0, 32'h1, 32'hFFFFFFFF, 32'h0000FFFF, 32'h0, 32'h80000000, 32'h08000000,
                            32'h12340000, 32'h1234ABCD, 32'hDEADBEEF, 32'h0, 32'h1, 32'h04000000};
   initial begin
      repeat (2) @(negedge clk);
      chk("reset result", res, 32'h0);
      chk("reset hi", hi, 32'h0);
      chk("reset zero", zero, 1'b1);
      chk("reset busy", busy, 1'b0);
      chk("reset done", done, 1'b0);
      rst = 1'b0;
      issue(4'h0, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 16'h0);
      chk("and done", done, 1'b1);
      chk("and result", res, 32'h00F000F0);
      chk("and zero", zero, 1'b0);
      chk("and busy", busy, 1'b0);
      @(negedge clk);
      chk("and done pulse", done, 1'b0);
      issue(4'h7, 32'hFFFFFFFF, 32'h1, 5'd0, 16'h0);
      chk("slt", res, 32'h1);
      issue(4'h5, 32'hFFFFFFFF, 32'h1, 5'd0, 16'h0);
      chk("sltu", res, 32'h0);
      issue(4'hE, 32'h0, 32'h80000000, 5'd4, 16'h0);
      chk("sra neg", res, 32'hF8000000);
      for (int i = 0; i < 13; i++) begin
         issue(t_c[i], t_a[i], t_b[i], t_s[i], t_i[i]);
         chk($sformatf("table %0d", i), res, t_e[i]);
      end
      @(negedge clk);
      drive(4'h2, 32'd1, 32'd2, 5'd0, 16'h0);
      @(negedge clk);
      chk("b2b add", res, 32'd3);
      drive(4'h6, 32'd10, 32'd3, 5'd0, 16'h0);
      @(negedge clk);
      chk("b2b sub", res, 32'd7);
      chk("b2b done", done, 1'b1);
      start = 1'b0;
      issue(4'h8, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 16'h0);
      wait_done(1, cyc, bc);
      chk("mul latency", cyc, 33);
      chk("mul busy cycles", bc, 32);
      chk("mul result", res, 32'h00000001);
      chk("mul hi", hi, 32'hFFFFFFFE);
      issue(4'h8, 32'd3, 32'd5, 5'd0, 16'h0);
      repeat (4) @(negedge clk);
      drive(4'h2, 32'd1, 32'd1, 5'd0, 16'h0);
      @(negedge clk);
      start = 1'b0;
      wait_done(6, cyc, bc);
      chk("interlock latency", cyc, 33);
      chk("interlock mul result", res, 32'd15);
      chk("interlock mul hi", hi, 32'd0);
      drive(4'h2, 32'd1, 32'd1, 5'd0, 16'h0);
      @(negedge clk);
      start = 1'b0;
      chk("done-cycle add done", done, 1'b1);
      chk("done-cycle add result", res, 32'd2);
      chk("done-cycle add busy", busy, 1'b0);
`ifdef ALU_MC_DIV_EN
      issue(4'hB, 32'd100, 32'd7, 5'd0, 16'h0);
      wait_done(1, cyc, bc);
      chk("div latency", cyc, 33);
      chk("div quotient", res, 32'd14);
      chk("div remainder", hi, 32'd2);
      issue(4'hB, 32'd5, 32'd0, 5'd0, 16'h0);
      wait_done(1, cyc, bc);
      chk("div0 quotient", res, 32'hFFFFFFFF);
      chk("div0 remainder", hi, 32'd5);
`else
      issue(4'hB, 32'd100, 32'd7, 5'd0, 16'h0);
      chk("undef done", done, 1'b1);
      chk("undef result", res, 32'h0);
      chk("undef zero", zero, 1'b1);
      chk("undef busy", busy, 1'b0);
`endif
      issue(4'h8, 32'd7, 32'd9, 5'd0, 16'h0);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort result", res, 32'h0);
      chk("abort hi", hi, 32'h0);
      chk("abort zero", zero, 1'b1);
      chk("abort busy", busy, 1'b0);
      chk("abort done", done, 1'b0);
      bc = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) bc++;
      end
      chk("abort no done", bc, 0);
      issue(4'h2, 32'd2, 32'd3, 5'd0, 16'h0);
      chk("post-abort add", res, 32'd5);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
